avmm_button_debounce_pio: RTL and testbench
===========================================

Name: avmm_button_debounce_pio

Overview:
- Avalon-MM responder (slave) for the board pushbuttons: the peripheral end of the interface the Nios II master drives.
- Synchronizes and debounces raw button pins, tracks press edges, and raises a maskable interrupt.
- The Nios II reads the debounced state and edge flags over the bus.
- Sits inside the Qsys system between the top-level PB pins and the processor data master; replaces a plain input PIO.

Parameters:
- WIDTH, 4, number of button inputs (1..32).
- DEBOUNCE_CYCLES, 50000, cycles an input must be stable before it is accepted (1 ms at 50 MHz); minimum 2.
- CNT_W, 16, debounce counter width; must satisfy 2^CNT_W > DEBOUNCE_CYCLES.
- ACTIVE_LOW, 1, 1 = pin reads 0 when pressed; 0 = pin reads 1 when pressed.

Ports:
- clk  in  1  system clock; all logic is on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- address  in  2  Avalon word address.
- read  in  1  Avalon read strobe.
- write  in  1  Avalon write strobe.
- writedata  in  32  Avalon write data.
- readdata  out  32  Avalon read data; fixed read latency of 1.
- irq  out  1  level interrupt to the Nios II.
- button_in  in  WIDTH  raw asynchronous button pins.
- pressed_out  out  WIDTH  debounced, polarity-normalized state (1 = pressed), for local use.

Behaviour:
- Reset is asynchronous and active-high, and applies to everything:
  - synchronizer flops = released level (all 1s if ACTIVE_LOW, else 0s);
  - stable state = released, so pressed_out = 0;
  - counters = 0, edge_cap = 0, irq_mask = 0, readdata = 0, irq = 0.
- Synchronizer: two flops per bit. The raw-to-sync latency is 2 cycles. Inputs are normalized to pressed = 1 after synchronization.
- Debounce (per bit, independent):
  - If the synced value equals the stable value, the counter clears to 0.
  - Otherwise the counter increments.
  - When the counter equals DEBOUNCE_CYCLES-1 and the synced value still differs, the stable value takes the synced value and the counter clears.
  - A glitch shorter than DEBOUNCE_CYCLES clears the counter and never changes the stable value.
  - Latency from pin change to pressed_out change = 2 + DEBOUNCE_CYCLES cycles.
- Press edge: a stable 0->1 transition (in pressed sense) sets edge_cap[i] on the same clock the stable value updates. Releases do not set edge_cap.
- Register map (reads return zeros above WIDTH):
  - addr 0 DATA: read-only, returns pressed_out.
  - addr 1 IRQ_MASK: read/write WIDTH bits; a write takes effect the next cycle.
  - addr 2 EDGE_CAP: read; writing 1 to a bit clears it; writing 0 has no effect.
  - addr 3 RAW: read-only, returns the synchronized, normalized inputs.
- Writes to addr 0 and addr 3 are ignored.
- Simultaneous W1C clear and new press edge on the same bit, same cycle: the set wins and the bit stays 1.
- Read timing: readdata is registered, capturing the addressed register on the cycle read=1, so it is valid the following cycle. readdata holds its last value when read=0. There is no waitrequest; every access completes.
- Read and write in the same cycle: both are performed. The read returns the pre-write value.
- irq = registered OR-reduction of (edge_cap & irq_mask), so it lags edge_cap or mask changes by 1 cycle. irq stays high until software clears the flags or masks them.
- Reset mid-debounce: counters clear and no edge is recorded. After reset, a button already held down is debounced afresh and then produces a press edge.

Test Plan (DEBOUNCE_CYCLES=4, WIDTH=4, ACTIVE_LOW=1):
- Reset released, button_in=4'hF → pressed_out=0, irq=0; reads of addr 0..3 give 0, 0, 0, 0.
- button_in[0] driven to 0 and held → pressed_out[0]=1 exactly 6 cycles after the pin change; EDGE_CAP reads 32'h1; irq stays 0 (mask 0).
- Write IRQ_MASK=32'h1 with edge_cap[0]=1 → irq=1 two cycles after the write; write EDGE_CAP=32'h1 → edge_cap=0 and irq=0 one cycle later.
- Glitch: button_in[2]=0 for 3 cycles, then 1 → pressed_out[2] never rises, EDGE_CAP[2]=0; RAW[2] shows the 3-cycle pulse.
- A new press edge lands in the same cycle as a W1C of that bit → EDGE_CAP still reads 1 for that bit.
- Assert reset during a press debounce with counter=2 → all outputs 0 immediately. Holding the pin low after reset gives pressed_out=1 six cycles after reset deasserts, with EDGE_CAP set.

Source files
------------

// File: rtl/avmm_button_debounce_pio.sv
// Pushbutton responder for the Nios II data master: two-flop synchronizer, per-bit
// debounce, press-edge capture with write-1-to-clear, and a maskable level interrupt.
module avmm_button_debounce_pio #(
  parameter int WIDTH           = 4,
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int CNT_W           = 16,
  parameter bit ACTIVE_LOW      = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       address,
  input  logic             read,
  input  logic             write,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  output logic             irq,
  input  logic [WIDTH-1:0] button_in,
  output logic [WIDTH-1:0] pressed_out
);

  // Bus handshake: there is no waitrequest, so every strobe is accepted on the
  // clock where it is high. A read sampled on cycle N presents readdata on N+1
  // and readdata holds until the next read. A write commits on its strobe edge.

  localparam logic [WIDTH-1:0] RELEASED = {WIDTH{ACTIVE_LOW}};
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [WIDTH-1:0] sync1, sync2, raw_norm;
  logic [WIDTH-1:0] stable, stable_nxt, press_set;
  logic [WIDTH-1:0] edge_cap, irq_mask, w1c;
  logic [CNT_W-1:0] cnt     [WIDTH];
  logic [CNT_W-1:0] cnt_nxt [WIDTH];
  logic [31:0]      rd_mux;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1 <= RELEASED;
      sync2 <= RELEASED;
    end else begin
      sync1 <= button_in;
      sync2 <= sync1;
    end
  end

  assign raw_norm = ACTIVE_LOW ? ~sync2 : sync2;

  // A bit is accepted only after DEBOUNCE_CYCLES consecutive differing samples.
  always_comb begin
    stable_nxt = stable;
    press_set  = '0;
    for (int i = 0; i < WIDTH; i++) begin
      cnt_nxt[i] = '0;
      if (raw_norm[i] != stable[i]) begin
        if (cnt[i] == CNT_LAST) begin
          stable_nxt[i] = raw_norm[i];
          press_set[i]  = raw_norm[i];
        end else begin
          cnt_nxt[i] = cnt[i] + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stable <= '0;
      for (int i = 0; i < WIDTH; i++) cnt[i] <= '0;
    end else begin
      stable <= stable_nxt;
      for (int i = 0; i < WIDTH; i++) cnt[i] <= cnt_nxt[i];
    end
  end

  assign pressed_out = stable;
  assign w1c = (write && address == 2'd2) ? writedata[WIDTH-1:0] : '0;

  // A press edge landing with a clear of the same bit keeps the bit set.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      edge_cap <= '0;
      irq_mask <= '0;
      irq      <= 1'b0;
    end else begin
      edge_cap <= (edge_cap & ~w1c) | press_set;
      if (write && address == 2'd1) irq_mask <= writedata[WIDTH-1:0];
      irq <= |(edge_cap & irq_mask);
    end
  end

  always_comb begin
    rd_mux = '0;
    case (address)
      2'd0:    rd_mux[WIDTH-1:0] = stable;
      2'd1:    rd_mux[WIDTH-1:0] = irq_mask;
      2'd2:    rd_mux[WIDTH-1:0] = edge_cap;
      default: rd_mux[WIDTH-1:0] = raw_norm;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) readdata <= '0;
    else if (read) readdata <= rd_mux;
  end

  if (WIDTH < 32) begin : g_wd_unused
    logic unused_wd;
    assign unused_wd = ^writedata[31:WIDTH];
  end

endmodule

// File: tb/tb_avmm_button_debounce_pio.sv
// Bench for avmm_button_debounce_pio: directed vector table, hand sequences for reset
// mid-debounce, and random traffic checked against a sample-window reference model.
module tb_avmm_button_debounce_pio;

  localparam int D = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  address;
  logic        read, write;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic        irq;
  logic [3:0]  button_in;
  logic [3:0]  pressed_out;

  int n_vec = 0;
  int n_err = 0;

  avmm_button_debounce_pio #(
    .WIDTH(4), .DEBOUNCE_CYCLES(D), .CNT_W(4), .ACTIVE_LOW(1'b1)
  ) dut (
    .clk(clk), .reset(reset), .address(address), .read(read), .write(write),
    .writedata(writedata), .readdata(readdata), .irq(irq),
    .button_in(button_in), .pressed_out(pressed_out)
  );

  always #5 clk = ~clk;

  // Reference model: a button is accepted when the last D synchronized samples all
  // disagree with the accepted state; the synchronizer is a 2-deep pin queue.
  logic [3:0]  pin_q[$];
  logic [3:0]  samp_q[$];
  logic [3:0]  m_stable, m_edge, m_mask;
  logic        m_irq;
  logic [31:0] m_rdata;

  task automatic model_reset();
    pin_q = '{4'hF, 4'hF};
    samp_q.delete();
    m_stable = '0; m_edge = '0; m_mask = '0; m_irq = 1'b0; m_rdata = '0;
  endtask

  task automatic model_update();
    logic [3:0] s, set, clr;
    logic       all_diff;
    s = ~pin_q.pop_front();
    pin_q.push_back(button_in);
    m_irq = |(m_edge & m_mask);
    if (read) begin
      case (address)
        2'd0: m_rdata = {28'd0, m_stable};
        2'd1: m_rdata = {28'd0, m_mask};
        2'd2: m_rdata = {28'd0, m_edge};
        default: m_rdata = {28'd0, s};
      endcase
    end
    samp_q.push_back(s);
    if (samp_q.size() > D) void'(samp_q.pop_front());
    set = '0;
    for (int b = 0; b < 4; b++) begin
      all_diff = (samp_q.size() == D);
      foreach (samp_q[k]) if (samp_q[k][b] == m_stable[b]) all_diff = 1'b0;
      if (all_diff) begin
        m_stable[b] = s[b];
        set[b] = s[b];
      end
    end
    clr = (write && address == 2'd2) ? writedata[3:0] : 4'd0;
    m_edge = (m_edge & ~clr) | set;
    if (write && address == 2'd1) m_mask = writedata[3:0];
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
    end
  endtask

  task automatic check_model();
    check("model_pressed", {28'd0, pressed_out}, {28'd0, m_stable});
    check("model_irq", {31'd0, irq}, {31'd0, m_irq});
    check("model_rdata", readdata, m_rdata);
  endtask

  task automatic step();
    @(posedge clk);
    if (reset) model_reset();
    else model_update();
    #1;
    check_model();
  endtask

  task automatic set_bus(input logic [1:0] a, input logic r, input logic w, input logic [31:0] wd);
    address = a; read = r; write = w; writedata = wd;
  endtask

  typedef struct {
    logic [3:0]  pins;
    logic [1:0]  addr;
    logic        rd;
    logic        wr;
    logic [31:0] wdata;
    int          cyc;
    logic [3:0]  e_pressed;
    logic        e_irq;
    logic [31:0] e_rdata;
  } vec_t;

  vec_t vecs[29];

  initial begin
    int hold;
    vecs[0]  = '{4'hF, 2'd0, 1'b1, 1'b0, 32'h0, 1, 4'h0, 1'b0, 32'h0};
    vecs[1]  = '{4'hF, 2'd1, 1'b1, 1'b0, 32'h0, 1, 4'h0, 1'b0, 32'h0};
    vecs[2]  = '{4'hF, 2'd2, 1'b1, 1'b0, 32'h0, 1, 4'h0, 1'b0, 32'h0};
    vecs[3]  = '{4'hF, 2'd3, 1'b1, 1'b0, 32'h0, 1, 4'h0, 1'b0, 32'h0};
    vecs[4]  = '{4'hE, 2'd0, 1'b0, 1'b0, 32'h0, 5, 4'h0, 1'b0, 32'h0};
    vecs[5]  = '{4'hE, 2'd0, 1'b0, 1'b0, 32'h0, 1, 4'h1, 1'b0, 32'h0};
    vecs[6]  = '{4'hE, 2'd2, 1'b1, 1'b0, 32'h0, 1, 4'h1, 1'b0, 32'h1};
    vecs[7]  = '{4'hE, 2'd0, 1'b1, 1'b0, 32'h0, 1, 4'h1, 1'b0, 32'h1};
    vecs[8]  = '{4'hE, 2'd3, 1'b1, 1'b0, 32'h0, 1, 4'h1, 1'b0, 32'h1};
    vecs[9]  = '{4'hE, 2'd1, 1'b0, 1'b1, 32'h1, 1, 4'h1, 1'b0, 32'h1};
    vecs[10] = '{4'hE, 2'd0, 1'b0, 1'b0, 32'h0, 1, 4'h1, 1'b1, 32'h1};
    vecs[11] = '{4'hE, 2'd2, 1'b0, 1'b1, 32'h1, 1, 4'h1, 1'b1, 32'h1};
    vecs[12] = '{4'hE, 2'd0, 1'b0, 1'b0, 32'h0, 1, 4'h1, 1'b0, 32'h1};
    vecs[13] = '{4'hE, 2'd2, 1'b1, 1'b0, 32'h0, 1, 4'h1, 1'b0, 32'h0};
    vecs[14] = '{4'hA, 2'd3, 1'b1, 1'b0, 32'h0, 3, 4'h1, 1'b0, 32'h5};
    vecs[15] = '{4'hE, 2'd3, 1'b1, 1'b0, 32'h0, 1, 4'h1, 1'b0, 32'h5};
    vecs[16] = '{4'hE, 2'd3, 1'b1, 1'b0, 32'h0, 1, 4'h1, 1'b0, 32'h5};
    vecs[17] = '{4'hE, 2'd3, 1'b1, 1'b0, 32'h0, 1, 4'h1, 1'b0, 32'h1};
    vecs[18] = '{4'hE, 2'd0, 1'b0, 1'b0, 32'h0, 4, 4'h1, 1'b0, 32'h1};
    vecs[19] = '{4'hE, 2'd2, 1'b1, 1'b0, 32'h0, 1, 4'h1, 1'b0, 32'h0};
    vecs[20] = '{4'hC, 2'd0, 1'b0, 1'b0, 32'h0, 5, 4'h1, 1'b0, 32'h0};
    vecs[21] = '{4'hC, 2'd2, 1'b0, 1'b1, 32'h2, 1, 4'h3, 1'b0, 32'h0};
    vecs[22] = '{4'hC, 2'd2, 1'b1, 1'b0, 32'h0, 1, 4'h3, 1'b0, 32'h2};
    vecs[23] = '{4'hC, 2'd2, 1'b0, 1'b1, 32'h2, 1, 4'h3, 1'b0, 32'h2};
    vecs[24] = '{4'hC, 2'd2, 1'b1, 1'b0, 32'h0, 1, 4'h3, 1'b0, 32'h0};
    vecs[25] = '{4'hC, 2'd0, 1'b0, 1'b1, 32'hF, 1, 4'h3, 1'b0, 32'h0};
    vecs[26] = '{4'hC, 2'd0, 1'b1, 1'b0, 32'h0, 1, 4'h3, 1'b0, 32'h3};
    vecs[27] = '{4'hC, 2'd1, 1'b1, 1'b1, 32'h5, 1, 4'h3, 1'b0, 32'h1};
    vecs[28] = '{4'hC, 2'd1, 1'b1, 1'b0, 32'h0, 1, 4'h3, 1'b0, 32'h5};

    // Clock/reset
    reset = 1'b1;
    button_in = 4'hF;
    set_bus(2'd0, 1'b0, 1'b0, 32'h0);
    model_reset();
    step();
    step();
    reset = 1'b0;
    check("reset_pressed", {28'd0, pressed_out}, 32'h0);
    check("reset_irq", {31'd0, irq}, 32'h0);

    // Directed table
    foreach (vecs[v]) begin
      button_in = vecs[v].pins;
      set_bus(vecs[v].addr, vecs[v].rd, vecs[v].wr, vecs[v].wdata);
      repeat (vecs[v].cyc) step();
      check($sformatf("vec%0d_pressed", v), {28'd0, pressed_out}, {28'd0, vecs[v].e_pressed});
      check($sformatf("vec%0d_irq", v), {31'd0, irq}, {31'd0, vecs[v].e_irq});
      check($sformatf("vec%0d_rdata", v), readdata, vecs[v].e_rdata);
    end

    // Reset while bit 3 is mid-debounce (counter at 2)
    button_in = 4'h4;
    set_bus(2'd0, 1'b1, 1'b0, 32'h0);
    repeat (4) step();
    check("pre_reset_rdata", readdata, 32'h3);
    set_bus(2'd0, 1'b0, 1'b0, 32'h0);
    reset = 1'b1;
    #1;
    model_reset();
    check("async_reset_pressed", {28'd0, pressed_out}, 32'h0);
    check("async_reset_rdata", readdata, 32'h0);
    check("async_reset_irq", {31'd0, irq}, 32'h0);
    step();
    step();
    reset = 1'b0;
    repeat (5) step();
    check("post_reset_5cyc", {28'd0, pressed_out}, 32'h0);
    step();
    check("post_reset_6cyc", {28'd0, pressed_out}, 32'hB);
    set_bus(2'd2, 1'b1, 1'b0, 32'h0);
    step();
    check("post_reset_edge", readdata, 32'hB);

    // Random traffic
    hold = 0;
    for (int c = 0; c < 2000; c++) begin
      if (hold == 0) begin
        button_in = 4'($urandom_range(0, 15));
        hold = $urandom_range(1, 8);
      end
      hold--;
      set_bus(2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
              ($urandom_range(0, 3) == 0), $urandom);
      if ($urandom_range(0, 499) == 0) begin
        reset = 1'b1;
        #1;
        model_reset();
        check_model();
        step();
        reset = 1'b0;
      end else begin
        step();
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
